alu_flag_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one SET_FLAG compare/flag unit (32-bit in1/in2 -> Result, Flag[3:0]) between NREQ requesters. It accepts one request at a time and drives the shared unit's operands for EXEC_CYCLES cycles. It then captures Result/Flag and returns them to the winning requester over a valid/ready response channel. It also holds the flags of the last completed operation for status readout.

---
 rtl/alu_flag_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_alu_flag_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_flag_arbiter.sv
// alu_flag_arbiter
// Round-robin arbiter/sequencer sharing one SET_FLAG compare/flag unit between NREQ requesters.
// One request is accepted at a time. Its operands are held on the shared unit for EXEC_CYCLES
// cycles. Result/Flag are then captured and returned on a valid/ready response channel.
//
// Ports:
//   clk, reset_n            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready     per-requester request valid / one-hot accept strobe
//   req_in1/req_in2         flattened operands, requester i at [i*DATA_W +: DATA_W]
//   alu_in1/alu_in2         registered operands to the shared unit
//   alu_result/alu_flag     combinational Result/Flag from the shared unit
//   rsp_valid/rsp_ready     response handshake; rsp_id/rsp_result/rsp_flag payload
//   last_flag               Flag of the last captured operation
//   busy                    high whenever not idle
//   rsp_timeout             one-cycle pulse when a response is dropped
//
// Optional feature: define ALU_ARB_TIMEOUT_EN to drop a response that is not accepted within
// TIMEOUT cycles. Without it the response waits indefinitely and rsp_timeout is tied low.
module alu_flag_arbiter #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned NREQ        = 4,
   parameter int unsigned ID_W        = 2,
   parameter int unsigned EXEC_CYCLES = 1,
   parameter int unsigned TIMEOUT     = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ*DATA_W-1:0] req_in1,
   input  logic [NREQ*DATA_W-1:0] req_in2,
   output logic [NREQ-1:0]        req_ready,
   output logic [DATA_W-1:0]      alu_in1,
   output logic [DATA_W-1:0]      alu_in2,
   input  logic [DATA_W-1:0]      alu_result,
   input  logic [3:0]             alu_flag,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [ID_W-1:0]        rsp_id,
   output logic [DATA_W-1:0]      rsp_result,
   output logic [3:0]             rsp_flag,
   output logic [3:0]             last_flag,
   output logic                   busy,
   output logic                   rsp_timeout
);

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

   state_e              state_q, state_d;
   logic [ID_W-1:0]     ptr_q, ptr_d;
   logic [ID_W-1:0]     id_q, id_d;
   logic [DATA_W-1:0]   op1_q, op1_d;
   logic [DATA_W-1:0]   op2_q, op2_d;
   logic [DATA_W-1:0]   res_q, res_d;
   logic [3:0]          flag_q, flag_d;
   logic [3:0]          last_q, last_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                grant_vld;
   logic [ID_W-1:0]     grant_id;

   // A zero limit would drop every response on its first cycle; TIMEOUT must be at least 1.
   if (TIMEOUT == 0) begin : g_timeout_zero_unsupported
   end

   // (base + off) mod NREQ, with base < NREQ and off < NREQ.
   function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
      int s;
      s = int'(32'(base)) + off;
      if (s >= int'(NREQ)) s = s - int'(NREQ);
      return ID_W'(s);
   endfunction

   // Round-robin search: walk offsets downward so the smallest offset from ptr wins.
   always_comb begin
      grant_vld = 1'b0;
      grant_id  = '0;
      for (int i = int'(NREQ) - 1; i >= 0; i--) begin
         if (req_valid[wrap_add(ptr_q, i)]) begin
            grant_vld = 1'b1;
            grant_id  = wrap_add(ptr_q, i);
         end
      end
   end

`ifdef ALU_ARB_TIMEOUT_EN
   localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [TmoW-1:0] tmo_q, tmo_d;
   logic            pulse_q, pulse_d;
`endif

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      id_d      = id_q;
      op1_d     = op1_q;
      op2_d     = op2_q;
      res_d     = res_q;
      flag_d    = flag_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      req_ready = '0;
`ifdef ALU_ARB_TIMEOUT_EN
      tmo_d     = '0;
      pulse_d   = 1'b0;
`endif
      unique case (state_q)
         StIdle: begin
            // Gated by reset_n so no accept strobe is shown while reset holds the FSM.
            if (grant_vld && reset_n) begin
               req_ready[grant_id] = 1'b1;
               id_d    = grant_id;
               op1_d   = req_in1[32'(grant_id)*DATA_W +: DATA_W];
               op2_d   = req_in2[32'(grant_id)*DATA_W +: DATA_W];
               cnt_d   = 4'(EXEC_CYCLES);
               state_d = StExec;
            end
         end
         StExec: begin
            if (cnt_q == 4'd1) begin
               res_d   = alu_result;
               flag_d  = alu_flag;
               last_d  = alu_flag;
               state_d = StResp;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StResp: begin
            if (rsp_ready) begin
               ptr_d   = wrap_add(id_q, 1);
               state_d = StIdle;
            end
`ifdef ALU_ARB_TIMEOUT_EN
            else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
               ptr_d   = wrap_add(id_q, 1);
               pulse_d = 1'b1;
               state_d = StIdle;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
`endif
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         id_q    <= '0;
         op1_q   <= '0;
         op2_q   <= '0;
         res_q   <= '0;
         flag_q  <= '0;
         last_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         op1_q   <= op1_d;
         op2_q   <= op2_d;
         res_q   <= res_d;
         flag_q  <= flag_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef ALU_ARB_TIMEOUT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tmo_q   <= '0;
         pulse_q <= 1'b0;
      end else begin
         tmo_q   <= tmo_d;
         pulse_q <= pulse_d;
      end
   end
   assign rsp_timeout = pulse_q;
`else
   assign rsp_timeout = 1'b0;
`endif

   assign alu_in1    = op1_q;
   assign alu_in2    = op2_q;
   assign rsp_valid  = (state_q == StResp);
   assign rsp_id     = id_q;
   assign rsp_result = res_q;
   assign rsp_flag   = flag_q;
   assign last_flag  = last_q;
   assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_alu_flag_arbiter.sv
module tb_alu_flag_arbiter;

   localparam int DW = 32;
   localparam int NR = 4;
   localparam int IW = 2;
   localparam int EC = 3;
   localparam int TO = 16;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [NR-1:0]     req_valid, req_ready;
   logic [NR*DW-1:0]  req_in1, req_in2;
   logic [DW-1:0]     alu_in1, alu_in2, alu_result, rsp_result;
   logic [3:0]        alu_flag, rsp_flag, last_flag;
   logic              rsp_valid, rsp_ready, busy, rsp_timeout;
   logic [IW-1:0]     rsp_id;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_flag_arbiter #(
      .DATA_W(DW), .NREQ(NR), .ID_W(IW), .EXEC_CYCLES(EC), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_in1(req_in1),
      .req_in2(req_in2), .req_ready(req_ready), .alu_in1(alu_in1), .alu_in2(alu_in2),
      .alu_result(alu_result), .alu_flag(alu_flag), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_flag(rsp_flag),
      .last_flag(last_flag), .busy(busy), .rsp_timeout(rsp_timeout)
   );

   // Shared SET_FLAG unit: Result = in1 < in2; Flag = {N, Z, borrow, signed overflow} of in1-in2.
   function automatic logic [35:0] alu_ref(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] d;
      d = a - b;
      return {d[31], d == 32'd0, a < b, (a[31] != b[31]) && (d[31] != a[31]), 31'd0, a < b};
   endfunction

   always_comb {alu_flag, alu_result} = alu_ref(alu_in1, alu_in2);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level reference: an accepted operation is answered EC cycles later and
   // stays pending until accepted (or dropped on timeout).
   bit          m_busy, m_pulse;
   int          m_wait, m_id, m_ptr, m_tmo;
   logic [31:0] m_op1, m_op2, m_res;
   logic [3:0]  m_flag, m_last;

   task automatic model_reset();
      m_busy = 0; m_pulse = 0; m_wait = 0; m_id = 0; m_ptr = 0; m_tmo = 0;
      m_op1 = '0; m_op2 = '0; m_res = '0; m_flag = '0; m_last = '0;
   endtask

   function automatic int winner();
      for (int i = 0; i < NR; i++) begin
         int k = (m_ptr + i) % NR;
         if (req_valid[k]) return k;
      end
      return -1;
   endfunction

   task automatic model_check();
      int w = winner();
      logic [NR-1:0] er = '0;
      if (!m_busy && w >= 0) er[w] = 1'b1;
      chk("req_ready", req_ready, er);
      chk("busy", busy, m_busy);
      chk("rsp_valid", rsp_valid, m_busy && m_wait == 0);
      chk("alu_in1", alu_in1, m_op1);
      chk("alu_in2", alu_in2, m_op2);
      chk("last_flag", last_flag, m_last);
      chk("rsp_timeout", rsp_timeout, m_pulse);
      if (m_busy && m_wait == 0) begin
         chk("rsp_id", rsp_id, m_id);
         chk("rsp_result", rsp_result, m_res);
         chk("rsp_flag", rsp_flag, m_flag);
      end
   endtask

   task automatic model_adv();
      bit pulse_n = 0;
      int w = winner();
      if (!m_busy) begin
         if (w >= 0) begin
            m_busy = 1; m_wait = EC; m_id = w; m_tmo = 0;
            m_op1 = req_in1[w*DW +: DW];
            m_op2 = req_in2[w*DW +: DW];
         end
      end else if (m_wait > 0) begin
         m_wait--;
         if (m_wait == 0) begin
            {m_flag, m_res} = alu_ref(m_op1, m_op2);
            m_last = m_flag;
         end
      end else if (rsp_ready) begin
         m_busy = 0; m_ptr = (m_id + 1) % NR;
      end
`ifdef ALU_ARB_TIMEOUT_EN
      else if (m_tmo == TO - 1) begin
         m_busy = 0; m_ptr = (m_id + 1) % NR; pulse_n = 1;
      end else begin
         m_tmo++;
      end
`endif
      m_pulse = pulse_n;
   endtask

   // Inputs are set at the falling edge; outputs are sampled 1 time unit later.
   task automatic cyc();
      model_check();
      model_adv();
      @(negedge clk);
   endtask

   task automatic tick();
      #1;
      cyc();
   endtask

   task automatic set_ops(input int id, input logic [31:0] a, input logic [31:0] b);
      req_in1[id*DW +: DW] = a;
      req_in2[id*DW +: DW] = b;
   endtask

   typedef struct {
      int          id;
      logic [31:0] in1;
      logic [31:0] in2;
      logic [31:0] res;
      logic [3:0]  flag;
   } vec_t;

   vec_t vt[6];
   logic [31:0] rr_res[4];
   int pulses;

   initial begin
      vt[0] = '{0, 32'd2, 32'd3, 32'd1, 4'b1010};
      vt[1] = '{1, 32'd6, 32'd2, 32'd0, 4'b0000};
      vt[2] = '{3, 32'h8000_0000, 32'd1, 32'd0, 4'b0001};
      vt[3] = '{1, 32'd1, 32'h8000_0000, 32'd1, 4'b1011};
      vt[4] = '{0, 32'd5, 32'd9, 32'd1, 4'b1010};
      vt[5] = '{2, 32'd10, 32'd10, 32'd0, 4'b0100};
      rr_res = '{32'd0, 32'd1, 32'd1, 32'd1};

      reset_n = 1'b0; req_valid = 4'b0001; rsp_ready = 1'b0;
      req_in1 = '0; req_in2 = '0;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_alu_in1", alu_in1, 0);
      chk("rst_last_flag", last_flag, 0);
      @(negedge clk);
      reset_n = 1'b1; req_valid = '0; rsp_ready = 1'b1;

      // Single requests: accept at k, response at k+EC+1.
      for (int r = 0; r < 6; r++) begin
         req_valid = NR'(1) << vt[r].id;
         set_ops(vt[r].id, vt[r].in1, vt[r].in2);
         #1;
         chk($sformatf("v%0d_ready", r), req_ready, NR'(1) << vt[r].id);
         cyc();
         req_valid = '0;
         repeat (EC) tick();
         #1;
         chk($sformatf("v%0d_rsp_valid", r), rsp_valid, 1);
         chk($sformatf("v%0d_rsp_id", r), rsp_id, vt[r].id);
         chk($sformatf("v%0d_rsp_result", r), rsp_result, vt[r].res);
         chk($sformatf("v%0d_rsp_flag", r), rsp_flag, vt[r].flag);
         chk($sformatf("v%0d_last_flag", r), last_flag, vt[r].flag);
         cyc();
      end
      repeat (5) begin
         #1;
         chk("idle_last_flag", last_flag, 4'b0100);
         cyc();
      end

      // Leave ptr at 1, then reset in the middle of a req3 operation.
      req_valid = 4'b0001; tick();
      req_valid = '0; repeat (EC + 1) tick();
      req_valid = 4'b1000; tick();
      req_valid = '0; tick();
      reset_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_alu_in1", alu_in1, 0);
      chk("mid_rst_alu_in2", alu_in2, 0);
      chk("mid_rst_rsp_valid", rsp_valid, 0);
      chk("mid_rst_last_flag", last_flag, 0);
      chk("mid_rst_rsp_result", rsp_result, 0);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;

      // Round-robin with all four requesting: order 0,1,2,3,0.
      req_valid = 4'b1111;
      set_ops(0, 32'd6, 32'd2); set_ops(1, 32'd5, 32'd9);
      set_ops(2, 32'd1, 32'd3); set_ops(3, 32'd12, 32'd16);
      for (int j = 0; j < 5; j++) begin
         #1;
         chk($sformatf("rr%0d_grant", j), req_ready, NR'(1) << (j % 4));
         cyc();
         repeat (EC) tick();
         #1;
         chk($sformatf("rr%0d_rsp_id", j), rsp_id, j % 4);
         chk($sformatf("rr%0d_rsp_result", j), rsp_result, rr_res[j % 4]);
         cyc();
      end

      // Backpressure on req1 while others keep requesting.
      req_valid = 4'b0010; set_ops(1, 32'd3, 32'd7); rsp_ready = 1'b0;
      tick();
      req_valid = 4'b1111;
      repeat (EC) tick();
      for (int c = 0; c < 4; c++) begin
         #1;
         chk("bp_rsp_valid", rsp_valid, 1);
         chk("bp_rsp_id", rsp_id, 1);
         chk("bp_rsp_result", rsp_result, 1);
         chk("bp_rsp_flag", rsp_flag, 4'b1010);
         chk("bp_req_ready", req_ready, 0);
         chk("bp_busy", busy, 1);
         cyc();
      end
      rsp_ready = 1'b1; tick();
      #1;
      chk("bp_release_busy", busy, 0);
      chk("bp_release_grant", req_ready, 4'b0100);
      cyc();

`ifdef ALU_ARB_TIMEOUT_EN
      // Drop a response: finish the current op, then hold rsp_ready low on req3.
      req_valid = '0; repeat (EC + 1) tick();
      req_valid = 4'b1000; rsp_ready = 1'b0; tick();
      req_valid = 4'b0001;
      pulses = 0;
      repeat (EC + TO + 3) begin
         #1;
         if (rsp_timeout) pulses++;
         cyc();
      end
      chk("timeout_pulses", pulses, 1);
      rsp_ready = 1'b1;
`endif

      // Randomized traffic against the reference model.
      for (int c = 0; c < 2500; c++) begin
         req_valid = NR'($urandom_range(0, 15));
         for (int i = 0; i < NR; i++) begin
            set_ops(i, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom,
                       ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom);
         end
         rsp_ready = ($urandom_range(0, 9) < 7);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
